// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-to-host receiver.
// Used by ps2_rx and ps2_rx_fifo.
package ps2_pkg;

  // Deframer states: wait for start, 8 data bits, parity bit, stop bit.
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // Scancode prefixes: extended key and key release.
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  // Number of data bits in one frame.
  localparam int unsigned PS2_FRAME_BITS = 8;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small show-ahead FIFO for received PS/2 bytes.
// Pointers carry one extra wrap bit, so full and empty can be told apart
// without a separate counter. A push into a full FIFO is dropped unless a
// pop happens in the same cycle.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FIFO_BITS = 3
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             drop
);

  localparam int unsigned DEPTH = 1 << FIFO_BITS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [FIFO_BITS:0] wr_ptr;
  logic [FIFO_BITS:0] rd_ptr;
  logic empty;
  logic full;
  logic pop;
  logic wr_en;

  // Derive the status flags and decide whether this cycle's push and pop are accepted.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[FIFO_BITS] != rd_ptr[FIFO_BITS]) &&
            (wr_ptr[FIFO_BITS-1:0] == rd_ptr[FIFO_BITS-1:0]);
    pop   = pop_req & ~empty;
    wr_en = push & (~full | pop);
    drop  = push & full & ~pop;
    valid = ~empty;
    rdata = empty ? '0 : mem[rd_ptr[FIFO_BITS-1:0]];
  end

  // Advance the read and write pointers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; it needs no reset because rdata is masked while the FIFO is empty.
  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_ptr[FIFO_BITS-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronise, glitch-filter, deframe
// (start, 8 data LSB first, odd parity, stop) and queue good bytes.
// Optional scancode event decode: define PS2_RX_KEYEVENT_EN.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT      = 4,
  parameter int unsigned TIMEOUT   = 20000,
  parameter int unsigned FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  output logic       key_event,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended
);

  localparam int unsigned FCW = $clog2(FILT + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);

  logic clk_meta, clk_sync, data_meta, data_sync;
  logic clk_filt, clk_filt_q, data_filt;
  logic [FCW-1:0] clk_cnt, data_cnt;
  logic fall;

  ps2_state_e state, state_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic        par, par_nxt;
  logic        par_err, par_err_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic        push, perr, ferr;
  logic        fifo_drop;

  // Two-flop synchronisers; idle level of both lines is high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  // Clock line filter: level changes after FILT consecutive differing samples.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      clk_cnt    <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      if (clk_sync == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FCW'(FILT - 1)) begin
        clk_filt <= clk_sync;
        clk_cnt  <= '0;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

  // Data line filter, same rule as the clock line.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      data_filt <= 1'b1;
      data_cnt  <= '0;
    end else begin
      if (data_sync == data_filt) begin
        data_cnt <= '0;
      end else if (data_cnt == FCW'(FILT - 1)) begin
        data_filt <= data_sync;
        data_cnt  <= '0;
      end else begin
        data_cnt <= data_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_q & ~clk_filt;

  // Deframer state and datapath registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b1;
      par_err <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      par_err <= par_err_nxt;
      tcnt    <= tcnt_nxt;
    end
  end

  // Next-state logic: advance on each filtered falling edge; abort a frame when the edges stop arriving.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par;
    par_err_nxt = par_err;
    tcnt_nxt    = tcnt;
    push        = 1'b0;
    perr        = 1'b0;
    ferr        = 1'b0;
    if (state == IDLE) begin
      tcnt_nxt = '0;
      if (fall && !data_filt) begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
        par_nxt     = 1'b1;
      end
    end else if (fall) begin
      tcnt_nxt = '0;
      case (state)
        DATA: begin
          shreg_nxt = {data_filt, shreg[7:1]};
          par_nxt   = par ^ data_filt;
          if (bit_cnt == 3'(PS2_FRAME_BITS - 1)) state_nxt = PARITY;
          else bit_cnt_nxt = bit_cnt + 1'b1;
        end
        PARITY: begin
          par_err_nxt = (data_filt != par);
          state_nxt   = STOP;
        end
        STOP: begin
          if (!data_filt)   ferr = 1'b1;
          else if (par_err) perr = 1'b1;
          else              push = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tcnt == TW'(TIMEOUT - 1)) begin
      ferr      = 1'b1;
      state_nxt = IDLE;
      tcnt_nxt  = '0;
    end else begin
      tcnt_nxt = tcnt + 1'b1;
    end
  end

  ps2_rx_fifo #(
    .WIDTH     (8),
    .FIFO_BITS (FIFO_BITS)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (shreg),
    .pop_req (rx_ready),
    .rdata   (rx_data),
    .valid   (rx_valid),
    .drop    (fifo_drop)
  );

  // Registered status pulses, aligned with the cycle the pushed byte appears.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      err_parity <= perr;
      err_frame  <= ferr;
      overflow   <= fifo_drop;
    end
  end

`ifdef PS2_RX_KEYEVENT_EN
  logic ext_flag, rel_flag;

  // Prefix tracking and key event generation from every deframed good byte.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_flag     <= 1'b0;
      rel_flag     <= 1'b0;
      key_event    <= 1'b0;
      key_code     <= '0;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (perr || ferr) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (push) begin
        if (shreg == PS2_PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (shreg == PS2_PREFIX_REL) begin
          rel_flag <= 1'b1;
        end else begin
          key_event    <= 1'b1;
          key_code     <= shreg;
          key_release  <= rel_flag;
          key_extended <= ext_flag;
          ext_flag     <= 1'b0;
          rel_flag     <= 1'b0;
        end
      end
    end
  end
`else
  assign key_event    = 1'b0;
  assign key_code     = '0;
  assign key_release  = 1'b0;
  assign key_extended = 1'b0;
`endif

endmodule
